uart_tx: RTL and testbench

Serial transmitter for the UART datapath. It drains the transmit FIFO one word at a time and shifts each word out on `tx` as an 8N1-style frame: start bit, data bits LSB first, one stop bit. It sits between the FIFO's read port (show-ahead data, `empty` flag) and the board TX pin, and is the consumer end of the FIFO's producer/consumer pair.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 35 +++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Sizing helper keeps counters at least one bit wide for degenerate parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Width of a counter that must hold 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    if (v <= 2) return 1;
    return $clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read port plus serial line outputs of the UART transmitter.
// Handshake: fifo_data is valid whenever fifo_empty=0; fifo_read is a one-cycle
// pop strobe, and the word is taken on the same rising edge that sees fifo_read=1.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
);
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_read;
  logic                 tx;
  logic                 busy;
  logic                 done_tick;

  // The transmitter side.
  modport slave (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read,
    output tx,
    output busy,
    output done_tick
  );

  // The FIFO / environment side.
  modport master (
    output fifo_empty,
    output fifo_data,
    input  fifo_read,
    input  tx,
    input  busy,
    input  done_tick
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A clear restarts the period so every state begins on a full bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int            CW   = clog2_min1(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last  = (r_cnt == LAST);
  assign bit_end = w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one word from a show-ahead FIFO and sends it as
// start bit, DATA_BITS data bits LSB first, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus,
  output tx_state_t o_state
);

  localparam int            IW       = clog2_min1(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IW-1:0]        r_idx;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  tx_state_t            w_state_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [IW-1:0]        w_idx_next;
  logic                 w_tx_next;
  logic                 w_fifo_read;
  logic                 w_bit_end;
  logic                 w_clear;
  logic                 w_done_next;

  // Gated by reset so no pop can leak out while the block is held idle.
  assign w_fifo_read = (r_state == IDLE) && !bus.fifo_empty && !reset;

  // The timer idles at zero and restarts on every state change.
  assign w_clear = (r_state == IDLE) || (w_state_next != r_state);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .bit_end(w_bit_end)
  );

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_fifo_read) begin
          w_state_next = START;
          w_shift_next = bus.fifo_data;
          w_idx_next   = '0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_idx == LAST_IDX) begin
            w_state_next = STOP;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Line level is chosen from the state being entered so tx is a clean flop output.
  always_comb begin
    w_tx_next = UART_IDLE_LEVEL;
    case (w_state_next)
      START:   w_tx_next = UART_START_LEVEL;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = UART_IDLE_LEVEL;
    endcase
  end

  assign w_done_next = (r_state == STOP) && w_bit_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= UART_IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != IDLE);
      r_done  <= w_done_next;
    end
  end

  assign bus.fifo_read = w_fifo_read;
  assign bus.tx        = r_tx;
  assign bus.busy      = r_busy;
  assign bus.done_tick = r_done;
  assign o_state       = r_state;

  a_read_only_idle : assert property (@(posedge clk) disable iff (reset)
    bus.fifo_read |-> (r_state == IDLE));

  a_idle_line_high : assert property (@(posedge clk) disable iff (reset)
    (r_state == IDLE) |-> (bus.tx == UART_IDLE_LEVEL) && !bus.busy);

  a_done_single : assert property (@(posedge clk) disable iff (reset)
    bus.done_tick |=> !bus.done_tick);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-timing model checks two instances (4 and 1 clocks
// per bit) on every cycle, alongside hand-computed directed expectations.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(D)) bus0 ();
  uart_tx_if #(.DATA_BITS(D)) bus1 ();
  tx_state_t st0, st1;

  uart_tx #(.DATA_BITS(D), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .o_state(st0)
  );
  uart_tx #(.DATA_BITS(D), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .o_state(st1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FIFO driver ----------------
  logic [D-1:0] words0[$];
  logic [D-1:0] words1[$];
  int  pops0 = 0, pops1 = 0;
  int  rd0 = 0, rd1 = 0;
  bit  toggle0 = 1'b0;

  initial begin
    bus0.fifo_empty = 1'b1; bus0.fifo_data = '0;
    bus1.fifo_empty = 1'b1; bus1.fifo_data = '0;
    forever begin
      @(posedge clk);
      #1;
      rd0 = pops0;
      rd1 = pops1;
      if (toggle0) begin
        bus0.fifo_empty = ~bus0.fifo_empty;
        bus0.fifo_data  = D'($urandom);
      end else if (rd0 < words0.size()) begin
        bus0.fifo_empty = 1'b0;
        bus0.fifo_data  = words0[rd0];
      end else begin
        bus0.fifo_empty = 1'b1;
        bus0.fifo_data  = '0;
      end
      if (rd1 < words1.size()) begin
        bus1.fifo_empty = 1'b0;
        bus1.fifo_data  = words1[rd1];
      end else begin
        bus1.fifo_empty = 1'b1;
        bus1.fifo_data  = '0;
      end
    end
  end

  // ---------------- frame model ----------------
  // k counts cycles since the pop: bit b=(k-1)/cpb is start (0), data (1..D) or stop.
  function automatic logic frame_level(input logic [D-1:0] w, input int k, input int cpb);
    int b;
    b = (k - 1) / cpb;
    if (b == 0) return 1'b0;
    if (b <= D) return w[b-1];
    return 1'b1;
  endfunction

  logic         m_in[2]   = '{1'b0, 1'b0};
  logic         m_done[2] = '{1'b0, 1'b0};
  int           m_k[2]    = '{0, 0};
  logic [D-1:0] m_w[2];
  logic         m_emp, m_rd, m_tx, m_bsy, m_dn;
  logic         e_rd, e_tx, e_bsy, e_dn;
  logic [D-1:0] m_dat;
  int           m_cpb, m_f;

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (ch == 0) begin
        m_emp = bus0.fifo_empty; m_dat = bus0.fifo_data; m_rd = bus0.fifo_read;
        m_tx = bus0.tx; m_bsy = bus0.busy; m_dn = bus0.done_tick; m_cpb = 4;
      end else begin
        m_emp = bus1.fifo_empty; m_dat = bus1.fifo_data; m_rd = bus1.fifo_read;
        m_tx = bus1.tx; m_bsy = bus1.busy; m_dn = bus1.done_tick; m_cpb = 1;
      end
      m_f = (D + 2) * m_cpb;
      if (reset) begin
        e_rd = 1'b0; e_tx = 1'b1; e_bsy = 1'b0; e_dn = 1'b0;
        m_in[ch] = 1'b0; m_done[ch] = 1'b0;
      end else begin
        e_dn = m_done[ch];
        if (m_in[ch]) begin
          e_rd = 1'b0; e_tx = frame_level(m_w[ch], m_k[ch], m_cpb); e_bsy = 1'b1;
        end else begin
          e_rd = !m_emp; e_tx = 1'b1; e_bsy = 1'b0;
        end
        m_done[ch] = m_in[ch] && (m_k[ch] == m_f);
        if (m_in[ch]) begin
          if (m_k[ch] == m_f) m_in[ch] = 1'b0;
          else m_k[ch] = m_k[ch] + 1;
        end else if (e_rd) begin
          m_in[ch] = 1'b1; m_k[ch] = 1; m_w[ch] = m_dat;
          if (ch == 0) pops0++; else pops1++;
        end
      end
      check($sformatf("model ch%0d fifo_read", ch), 32'(m_rd), 32'(e_rd));
      check($sformatf("model ch%0d tx", ch), 32'(m_tx), 32'(e_tx));
      check($sformatf("model ch%0d busy", ch), 32'(m_bsy), 32'(e_bsy));
      check($sformatf("model ch%0d done_tick", ch), 32'(m_dn), 32'(e_dn));
    end
  end

  // ---------------- directed helpers ----------------
  // which: 0 = fifo_read, 1 = done_tick. Returns the cycle seen, or -1 on timeout.
  task automatic wait_sig(input int ch, input int which, input int limit, output int n);
    logic s;
    n = -1;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (ch == 0) s = (which == 0) ? bus0.fifo_read : bus0.done_tick;
      else         s = (which == 0) ? bus1.fifo_read : bus1.done_tick;
      if (s) begin
        n = cyc;
        break;
      end
    end
    check($sformatf("ch%0d %s seen", ch, (which == 0) ? "fifo_read" : "done_tick"),
          32'(n >= 0), 32'd1);
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  logic exp_a5[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic exp_81[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, m;

    // 1: reset, FIFO empty, line idle for 20 cycles
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle tx", 32'(bus0.tx), 32'd1);
      check("idle busy", 32'(bus0.busy), 32'd0);
      check("idle fifo_read", 32'(bus0.fifo_read), 32'd0);
      check("idle done_tick", 32'(bus0.done_tick), 32'd0);
    end
    check("idle state", 32'(st0), 32'(IDLE));

    // 2: single word 0xA5
    words0.push_back(8'hA5);
    wait_sig(0, 0, 20, n);
    @(negedge clk);
    check("a5 read one cycle", 32'(bus0.fifo_read), 32'd0);
    for (int j = 0; j < 10; j++) begin
      goto_cycle(n + 2 + 4 * j);
      check($sformatf("a5 bit%0d", j), 32'(bus0.tx), 32'(exp_a5[j]));
    end
    wait_sig(0, 1, 20, m);
    check("a5 done latency", 32'(m - n), 32'd41);
    repeat (5) @(negedge clk);

    // 3: back-to-back 0x00 then 0xFF
    words0.push_back(8'h00);
    words0.push_back(8'hFF);
    wait_sig(0, 0, 20, n);
    wait_sig(0, 0, 60, n2);
    check("b2b read spacing", 32'(n2 - n), 32'd41);
    for (int j = 0; j < 10; j++) begin
      goto_cycle(n2 + 2 + 4 * j);
      check($sformatf("ff bit%0d", j), 32'(bus0.tx), (j == 0) ? 32'd0 : 32'd1);
    end
    wait_sig(0, 1, 20, m);
    check("ff done latency", 32'(m - n2), 32'd41);
    repeat (5) @(negedge clk);

    // 4: reset during data bit 3 of 0x3C
    words0.push_back(8'h3C);
    wait_sig(0, 0, 20, n);
    goto_cycle(n + 18);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset tx", 32'(bus0.tx), 32'd1);
    check("async reset busy", 32'(bus0.busy), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("post reset fifo_read", 32'(bus0.fifo_read), 32'd0);
      check("post reset done_tick", 32'(bus0.done_tick), 32'd0);
    end

    // 5: fifo_empty toggling mid-frame must not cause pops
    words0.push_back(8'h5A);
    wait_sig(0, 0, 20, n);
    toggle0 = 1'b1;
    for (int c = n + 1; c <= n + 40; c++) begin
      goto_cycle(c);
      if (c == n + 30) toggle0 = 1'b0;
      check("read while busy", 32'(bus0.fifo_read & bus0.busy), 32'd0);
    end
    wait_sig(0, 1, 10, m);
    check("5a done latency", 32'(m - n), 32'd41);
    repeat (5) @(negedge clk);

    // 6: one clock per bit, word 0x81
    words1.push_back(8'h81);
    wait_sig(1, 0, 20, n);
    for (int j = 0; j < 10; j++) begin
      goto_cycle(n + 1 + j);
      check($sformatf("81 bit%0d", j), 32'(bus1.tx), 32'(exp_81[j]));
    end
    wait_sig(1, 1, 10, m);
    check("81 done latency", 32'(m - n), 32'd11);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
